// File: rtl/axil_corr_ctrl_if.sv
// AXI4-Lite bundle between the PS master port and the correlator control slave.
interface axil_corr_ctrl_if #(
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_corr_ctrl.sv
// AXI4-Lite register block for the correlator: config/status registers plus the
// clear -> run integration sequencer (single or continuous integrations).
module axil_corr_ctrl #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned K_W         = 10,
    parameter int unsigned CLR_CYCLES  = 4,
    parameter int unsigned ACC_DEFAULT = 1024
) (
    input  logic            axi_clock,
    input  logic            axi_rst_n,
    axil_corr_ctrl_if.slave s_axi,
    input  logic            sample_valid,
    input  logic            corr_ovf,
    output logic            corr_rst,
    output logic            corr_en,
    output logic [K_W-1:0]  corr_k,
    output logic            acc_last
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned ClrW  = $clog2(CLR_CYCLES) + 1;
    localparam logic [IDX_W-1:0] IdxCtrl = IDX_W'(0);
    localparam logic [IDX_W-1:0] IdxLen  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IdxK    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IdxStat = IDX_W'(3);
    localparam logic [IDX_W-1:0] IdxCnt  = IDX_W'(4);

    typedef enum logic [1:0] {StIdle, StClr, StRun} state_e;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // Write channel state
    logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic             bvalid_q, bvalid_d, awready_q, wready_q;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             aw_hs, w_hs, do_write;
    // Read channel state
    logic             arready_q, rvalid_q, rvalid_d, ar_hs;
    logic [31:0]      rdata_q, rd_mux;
    logic [IDX_W-1:0] ar_idx;
    // Registers
    logic             ctrl_cont_q, done_q, ovf_q;
    logic [31:0]      acc_len_q, int_cnt_q, k_merge;
    logic [K_W-1:0]   dft_k_q;
    logic             wr_ctrl, start_wr, abort_wr, stat_w1c, busy;
    // Sequencer
    state_e           state_q, state_d;
    logic [ClrW-1:0]  clr_cnt_q, clr_cnt_d;
    logic [31:0]      cnt_q, cnt_d, len_m1_q, len_m1_d;
    logic             abort_rst_q, abort_rst_d, last_hit;

    assign aw_hs    = s_axi.awvalid && awready_q;
    assign w_hs     = s_axi.wvalid && wready_q;
    assign do_write = aw_held_q && w_held_q;
    assign ar_hs    = s_axi.arvalid && arready_q;
    assign ar_idx   = s_axi.araddr[ADDR_W-1:2];

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        if (do_write) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else begin
            if (aw_hs) aw_held_d = 1'b1;
            if (w_hs) w_held_d = 1'b1;
            if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;
        end
        rvalid_d = rvalid_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge axi_clock) begin
        if (!axi_rst_n) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            // Readies are registered from next-state so a held beat is never re-accepted
            awready_q <= !aw_held_d && !bvalid_d;
            wready_q  <= !w_held_d && !bvalid_d;
            if (aw_hs) aw_idx_q <= s_axi.awaddr[ADDR_W-1:2];
            if (w_hs) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
            arready_q <= !rvalid_d;
            rvalid_q  <= rvalid_d;
            if (ar_hs) rdata_q <= rd_mux;
        end
    end

    assign wr_ctrl  = do_write && (aw_idx_q == IdxCtrl) && wstrb_q[0];
    assign start_wr = wr_ctrl && wdata_q[0];
    assign abort_wr = wr_ctrl && wdata_q[1];
    assign stat_w1c = do_write && (aw_idx_q == IdxStat) && wstrb_q[0];
    assign busy     = (state_q != StIdle);
    assign k_merge  = lane_merge(32'(dft_k_q), wdata_q, wstrb_q);

    always_comb begin
        case (ar_idx)
            IdxCtrl: rd_mux = {29'd0, ctrl_cont_q, 2'b00};
            IdxLen:  rd_mux = acc_len_q;
            IdxK:    rd_mux = 32'(dft_k_q);
            IdxStat: rd_mux = {29'd0, ovf_q, done_q, busy};
            IdxCnt:  rd_mux = int_cnt_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge axi_clock) begin
        if (!axi_rst_n) begin
            ctrl_cont_q <= 1'b0;
            acc_len_q   <= 32'(ACC_DEFAULT);
            dft_k_q     <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            int_cnt_q   <= '0;
        end else begin
            if (do_write) begin
                case (aw_idx_q)
                    IdxCtrl: if (wstrb_q[0]) ctrl_cont_q <= wdata_q[2];
                    IdxLen:  acc_len_q <= lane_merge(acc_len_q, wdata_q, wstrb_q);
                    IdxK:    dft_k_q <= k_merge[K_W-1:0];
                    default: ;
                endcase
            end
            // Set beats a simultaneous W1C
            done_q <= last_hit || (done_q && !(stat_w1c && wdata_q[1]));
            ovf_q  <= corr_ovf || (ovf_q && !(stat_w1c && wdata_q[2]));
            if (start_wr && !abort_wr && !busy) begin
                int_cnt_q <= '0;
            end else if (last_hit) begin
                int_cnt_q <= int_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        cnt_d       = cnt_q;
        len_m1_d    = len_m1_q;
        abort_rst_d = 1'b0;
        last_hit    = 1'b0;
        if (abort_wr) begin
            state_d     = StIdle;
            abort_rst_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_wr) begin
                        state_d   = StClr;
                        clr_cnt_d = '0;
                        cnt_d     = '0;
                        len_m1_d  = (acc_len_q == 32'd0) ? 32'd0 : acc_len_q - 32'd1;
                    end
                end
                StClr: begin
                    if (clr_cnt_q == ClrW'(CLR_CYCLES - 1)) begin
                        state_d = StRun;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (sample_valid) begin
                        if (cnt_q == len_m1_q) begin
                            last_hit = 1'b1;
                            cnt_d    = '0;
                            if (!ctrl_cont_q) state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge axi_clock) begin
        if (!axi_rst_n) begin
            state_q     <= StIdle;
            clr_cnt_q   <= '0;
            cnt_q       <= '0;
            len_m1_q    <= '0;
            abort_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            cnt_q       <= cnt_d;
            len_m1_q    <= len_m1_d;
            abort_rst_q <= abort_rst_d;
        end
    end

    assign corr_rst = (state_q == StClr) || abort_rst_q;
    assign corr_en  = (state_q == StRun);
    assign corr_k   = dft_k_q;
    assign acc_last = last_hit;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    logic unused_ok;
    assign unused_ok = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.awprot, s_axi.arprot,
                         k_merge[31:K_W]};
endmodule

// File: tb/tb_axil_corr_ctrl.sv
// Self-checking bench for axil_corr_ctrl: register vector table, hand-written
// integration/handshake sequences and randomized runs against an arithmetic model.
module tb_axil_corr_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_valid, corr_ovf;
    logic       corr_rst, corr_en, acc_last;
    logic [9:0] corr_k;
    int         tests = 0;
    int         fails = 0;
    int         mon_rst = 0;
    int         mon_lasts = 0;
    logic       q_last[$];

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[14];

    axil_corr_ctrl_if #(.ADDR_W(5)) s_axi ();

    axil_corr_ctrl #(.ADDR_W(5), .K_W(10), .CLR_CYCLES(4), .ACC_DEFAULT(1024)) dut (
        .axi_clock    (clk),
        .axi_rst_n    (rst_n),
        .s_axi        (s_axi),
        .sample_valid (sample_valid),
        .corr_ovf     (corr_ovf),
        .corr_rst     (corr_rst),
        .corr_en      (corr_en),
        .corr_k       (corr_k),
        .acc_last     (acc_last)
    );

    always #5 clk = ~clk;

    // Records acc_last for every sample consumed inside the enable window
    always @(negedge clk) begin
        if (corr_rst) mon_rst++;
        if (acc_last) mon_lasts++;
        if (corr_en && sample_valid) q_last.push_back(acc_last);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int   t;
        logic aw_ok, w_ok;
        @(negedge clk);
        s_axi.awaddr = addr; s_axi.awvalid = 1'b1;
        s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wvalid = 1'b1; s_axi.bready = 1'b1;
        t = 0;
        while ((s_axi.awvalid || s_axi.wvalid) && t < 40) begin
            aw_ok = s_axi.awvalid && s_axi.awready;
            w_ok  = s_axi.wvalid && s_axi.wready;
            @(negedge clk);
            if (aw_ok) s_axi.awvalid = 1'b0;
            if (w_ok) s_axi.wvalid = 1'b0;
            t++;
        end
        while (!s_axi.bvalid && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            timeout_fail("axi write");
            s_axi.awvalid = 1'b0;
            s_axi.wvalid  = 1'b0;
        end
        @(negedge clk);
        s_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        int t;
        @(negedge clk);
        s_axi.araddr = addr; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
        t = 0;
        while (!s_axi.arready && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        check("read latency rvalid", {31'd0, s_axi.rvalid}, 32'd1);
        while (!s_axi.rvalid && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            timeout_fail("axi read");
            data = 32'hxxxx_xxxx;
        end else begin
            data = s_axi.rdata;
        end
        s_axi.rready = 1'b1;
        @(negedge clk);
        s_axi.rready = 1'b0;
    endtask

    task automatic wait_en();
        int t = 0;
        while (!corr_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!corr_en) timeout_fail("wait corr_en");
    endtask

    // Expected: acc_last on every len-th sample; only the first integration unless continuous
    task automatic check_run(input string name, input int unsigned leff, input bit cont,
                             input int unsigned exp_n);
        check({name, " samples"}, q_last.size(), exp_n);
        for (int i = 0; i < q_last.size(); i++) begin
            logic e;
            e = (((i + 1) % leff) == 0) && (cont || ((i + 1) == leff));
            check({name, " acc_last"}, {31'd0, q_last[i]}, {31'd0, e});
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          t;
        vecs[0]  = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h0000_0400};
        vecs[1]  = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h0};
        vecs[2]  = '{1'b0, 5'h0C, 32'h0,         4'h0, 32'h0};
        vecs[3]  = '{1'b0, 5'h10, 32'h0,         4'h0, 32'h0};
        vecs[4]  = '{1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF, 32'h0000_03FF};
        vecs[5]  = '{1'b1, 5'h04, 32'hFFFF_FFAA, 4'h1, 32'h0000_04AA};
        vecs[6]  = '{1'b1, 5'h04, 32'h1234_5678, 4'h6, 32'h0034_56AA};
        vecs[7]  = '{1'b1, 5'h00, 32'h4,         4'hF, 32'h4};
        vecs[8]  = '{1'b1, 5'h00, 32'h0,         4'hE, 32'h4};
        vecs[9]  = '{1'b1, 5'h00, 32'h0,         4'h1, 32'h0};
        vecs[10] = '{1'b1, 5'h14, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[11] = '{1'b1, 5'h0C, 32'h7,         4'hF, 32'h0};
        vecs[12] = '{1'b0, 5'h1C, 32'h0,         4'h0, 32'h0};
        vecs[13] = '{1'b1, 5'h08, 32'h0,         4'h3, 32'h0};

        rst_n = 1'b0; sample_valid = 1'b0; corr_ovf = 1'b0;
        s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {s_axi.awready, s_axi.wready, s_axi.arready, s_axi.bvalid,
              s_axi.rvalid, corr_rst, corr_en, acc_last, 14'd0, corr_k}, 32'd0);
        check("reset rdata", s_axi.rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("readies after reset", {29'd0, s_axi.awready, s_axi.wready, s_axi.arready}, 32'd7);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            axi_read(vecs[i].addr, rd);
            check($sformatf("vector %0d", i), rd, vecs[i].exp);
        end

        // Single integration of 8 samples, sample_valid every cycle
        axi_write(5'h04, 32'd8, 4'hF);
        sample_valid = 1'b1;
        mon_rst = 0; mon_lasts = 0; q_last.delete();
        axi_write(5'h00, 32'h1, 4'hF);
        t = 0;
        while (mon_lasts < 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (mon_lasts < 1) timeout_fail("single run acc_last");
        repeat (2) @(negedge clk);
        sample_valid = 1'b0;
        check("single clr cycles", mon_rst, 32'd4);
        check_run("single", 8, 1'b0, 8);
        check("single corr_en off", {31'd0, corr_en}, 32'd0);
        axi_read(5'h0C, rd); check("single status", rd, 32'h2);
        axi_read(5'h10, rd); check("single int_cnt", rd, 32'd1);

        // W leads AW by 3 cycles, bready held low for 5 cycles, second beats offered
        @(negedge clk);
        s_axi.wdata = 32'h55; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
        @(negedge clk);
        check("w-first wready low", {31'd0, s_axi.wready}, 32'd0);
        s_axi.wdata = 32'hAA;
        repeat (2) @(negedge clk);
        s_axi.awaddr = 5'h08; s_axi.awvalid = 1'b1;
        t = 0;
        while (!s_axi.bvalid && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (!s_axi.bvalid) timeout_fail("w-first bvalid");
        for (int c = 0; c < 5; c++) begin
            check("hold bvalid/readies", {29'd0, s_axi.bvalid, s_axi.awready, s_axi.wready}, 32'd4);
            @(negedge clk);
        end
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b1;
        @(negedge clk);
        s_axi.bready = 1'b0;
        check("bvalid released", {31'd0, s_axi.bvalid}, 32'd0);
        axi_read(5'h08, rd); check("w-first data", rd, 32'h55);
        check("corr_k", {22'd0, corr_k}, 32'h55);

        // Continuous integrations of 3, then clear CONT to finish the open one
        axi_write(5'h04, 32'd3, 4'hF);
        mon_lasts = 0; q_last.delete();
        axi_write(5'h00, 32'h5, 4'hF);
        wait_en();
        sample_valid = 1'b1;
        repeat (10) @(negedge clk);
        sample_valid = 1'b0;
        check("cont acc_last count", mon_lasts, 32'd3);
        axi_read(5'h10, rd); check("cont int_cnt", rd, 32'd3);
        axi_read(5'h0C, rd); check("cont busy", rd & 32'h1, 32'h1);
        axi_write(5'h00, 32'h0, 4'hF);
        sample_valid = 1'b1;
        t = 0;
        while (corr_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        sample_valid = 1'b0;
        if (corr_en) timeout_fail("cont finish");
        check_run("cont", 3, 1'b1, 12);
        axi_read(5'h10, rd); check("cont final int_cnt", rd, 32'd4);
        axi_read(5'h0C, rd); check("cont final status", rd, 32'h2);

        // Abort partway through an 8-sample integration
        axi_write(5'h0C, 32'h2, 4'hF);
        axi_write(5'h04, 32'd8, 4'hF);
        q_last.delete();
        axi_write(5'h00, 32'h1, 4'hF);
        wait_en();
        sample_valid = 1'b1;
        repeat (4) @(negedge clk);
        sample_valid = 1'b0;
        mon_rst = 0;
        axi_write(5'h00, 32'h3, 4'hF);
        check("abort corr_en", {31'd0, corr_en}, 32'd0);
        check("abort corr_rst pulse", mon_rst, 32'd1);
        check_run("abort", 8, 1'b0, 4);
        axi_read(5'h0C, rd); check("abort status", rd, 32'h0);
        axi_read(5'h10, rd); check("abort int_cnt", rd, 32'd0);

        // ACC_LEN of zero behaves as one
        axi_write(5'h04, 32'd0, 4'hF);
        mon_lasts = 0; q_last.delete();
        axi_write(5'h00, 32'h1, 4'hF);
        wait_en();
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_run("len0", 1, 1'b0, 1);
        check("len0 acc_last count", mon_lasts, 32'd1);
        check("len0 corr_en off", {31'd0, corr_en}, 32'd0);
        axi_read(5'h10, rd); check("len0 int_cnt", rd, 32'd1);

        // OVF set coincident with its W1C: set wins
        repeat (3) @(negedge clk);
        check("ovf awready", {31'd0, s_axi.awready}, 32'd1);
        s_axi.awaddr = 5'h0C; s_axi.awvalid = 1'b1;
        s_axi.wdata = 32'h4; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1; s_axi.bready = 1'b1;
        @(negedge clk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; corr_ovf = 1'b1;
        @(negedge clk);
        corr_ovf = 1'b0;
        check("ovf write bvalid", {31'd0, s_axi.bvalid}, 32'd1);
        @(negedge clk);
        s_axi.bready = 1'b0;
        axi_read(5'h0C, rd); check("ovf set wins", rd & 32'h4, 32'h4);
        axi_write(5'h0C, 32'h4, 4'hF);
        axi_read(5'h0C, rd); check("ovf cleared", rd & 32'h4, 32'h0);

        // Randomized integrations against the arithmetic model
        for (int it = 0; it < 8; it++) begin
            int unsigned len, leff, s, exp_cnt;
            bit          cont, exp_busy;
            len  = $urandom_range(0, 5);
            cont = 1'($urandom_range(0, 1));
            leff = (len == 0) ? 1 : len;
            axi_write(5'h0C, 32'h2, 4'hF);
            axi_write(5'h04, len, 4'hF);
            q_last.delete();
            axi_write(5'h00, {29'd0, cont, 2'b01}, 4'hF);
            wait_en();
            s = 0;
            for (int c = 0; c < 16; c++) begin
                sample_valid = 1'($urandom_range(0, 1));
                if (sample_valid) s++;
                @(negedge clk);
            end
            sample_valid = 1'b0;
            @(negedge clk);
            exp_cnt  = cont ? s / leff : ((s >= leff) ? 1 : 0);
            exp_busy = cont ? 1'b1 : (s < leff);
            axi_read(5'h10, rd); check($sformatf("rand %0d int_cnt", it), rd, exp_cnt);
            axi_read(5'h0C, rd);
            check($sformatf("rand %0d status", it), rd, {30'd0, exp_cnt != 0, exp_busy});
            check_run($sformatf("rand %0d", it), leff, cont, cont ? s : ((s < leff) ? s : leff));
            if (exp_busy) axi_write(5'h00, 32'h2, 4'hF);
        end

        // Reset with a write response pending drops it
        @(negedge clk);
        s_axi.awaddr = 5'h08; s_axi.awvalid = 1'b1;
        s_axi.wdata = 32'h123; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
        @(negedge clk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset bvalid", {31'd0, s_axi.bvalid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset drops bvalid", {30'd0, s_axi.bvalid, s_axi.awready}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        axi_read(5'h08, rd); check("reset clears dft_k", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
